// File: rtl/loader_pkg.sv
// Shared types and constants for the CPU program loader.
package loader_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_RST  = 3'd1,
        BURST    = 3'd2,
        POST_RST = 3'd3,
        RUN      = 3'd4
    } loaderStateT;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] PAD_WORD       = 32'h0;
endpackage

// File: rtl/loader_fifo.sv
// Instruction word FIFO with registered read data and async clear.
module loader_fifo
    import loader_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   pushData,
    output logic [31:0]   rdData,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic          doPush, doPop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    // rdData carries the popped word for exactly one cycle and is NOP otherwise,
    // so it can drive the CPU instruction bus directly.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            rdData <= PAD_WORD;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            rdData <= doPop ? mem[rdPtr] : PAD_WORD;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/program_loader.sv
// Packs a byte stream into instruction words and bursts them into the CPU
// between two reset pulses.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic          load_go,
    output logic          cpu_reset,
    output logic          LoadInstructions,
    output logic [31:0]   Instruction,
    output logic [AW:0]   word_count,
    output logic          busy
);
    loaderStateT state, nextState;
    logic [1:0]  byteIdx, nextIdx;
    logic [31:0] wordBuf, mergedWord;
    logic        acceptPhase, accept, goNow, push, pop, fifoFull, fifoEmpty;

    assign acceptPhase = (state == IDLE) || (state == RUN);
    assign byte_ready  = !Reset && acceptPhase && !fifoFull;
    assign accept      = byte_valid && byte_ready;
    assign goNow       = load_go && acceptPhase;
    assign nextIdx     = byteIdx + {1'b0, accept};

    always_comb begin
        mergedWord = wordBuf;
        if (accept) begin
            case (byteIdx)
                2'd0:    mergedWord[31:24] = byte_data;
                2'd1:    mergedWord[23:16] = byte_data;
                2'd2:    mergedWord[15:8]  = byte_data;
                default: mergedWord[7:0]   = byte_data;
            endcase
        end
    end

    // A full word pushes on its last byte; a partial word (unfilled lanes
    // already zero) pushes on load_go unless the FIFO has no room.
    assign push = (accept && byteIdx == 2'(BYTES_PER_WORD - 1))
               || (goNow && nextIdx != 2'd0 && !fifoFull);

    always_comb begin
        nextState = state;
        case (state)
            IDLE, RUN: if (load_go) nextState = PRE_RST;
            PRE_RST:   nextState = fifoEmpty ? POST_RST : BURST;
            BURST:     if (fifoEmpty) nextState = POST_RST;
            POST_RST:  nextState = RUN;
            default:   nextState = IDLE;
        endcase
    end

    // Popping on entry to each BURST cycle lands the word in the registered
    // read port exactly while LoadInstructions is high.
    assign pop = (nextState == BURST);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            byteIdx          <= '0;
            wordBuf          <= PAD_WORD;
            cpu_reset        <= 1'b1;
            LoadInstructions <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state <= nextState;
            if (push || goNow) begin
                byteIdx <= '0;
                wordBuf <= PAD_WORD;
            end else if (accept) begin
                byteIdx <= nextIdx;
                wordBuf <= mergedWord;
            end
            cpu_reset        <= !(nextState == BURST || nextState == RUN);
            LoadInstructions <= (nextState == BURST);
            busy             <= (nextState == PRE_RST) || (nextState == BURST)
                             || (nextState == POST_RST);
        end
    end

    loader_fifo #(.DEPTH(DEPTH), .AW(AW)) fifo (
        .clk      (clk),
        .Reset    (Reset),
        .push     (push),
        .pop      (pop),
        .pushData (mergedWord),
        .rdData   (Instruction),
        .count    (word_count),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );
endmodule
